// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder memory model.
package mem_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {PORT_IFU, PORT_LSU} port_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [31:0] DEFAULT_BASE     = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_OOR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_responder_ram.sv
// Word-organised single-port RAM with byte-lane write enables and registered read.
module mem_responder_ram #(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Two-port (fetch / load-store) memory responder with fixed response latency.
// Define MEM_RESPONDER_RANDOM_DELAY_EN to add 0-3 LFSR-driven wait cycles per transaction.
//
// state | meaning
// IDLE  | arbitrate ifu/lsu requests, latch the granted one
// WAIT  | count down the remaining latency
// RESP  | one-cycle respValid pulse on the granted port
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH    = 16384,
  parameter logic [31:0] BASE     = DEFAULT_BASE,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] OOR_DATA = DEFAULT_OOR_DATA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = $clog2(LATENCY + 4) + 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return ({1'b0, off} < LIMIT);
  endfunction

  state_t         state_q, state_d;
  port_t          port_q, port_d, last_grant_q, last_grant_d, grant;
  logic [31:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic           wen_q, wen_d;
  logic [3:0]     wmask_q, wmask_d;
  logic [CW-1:0]  cnt_q, cnt_d, total;
  logic [31:0]    ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic [1:0]     extra;
  logic           ram_en, ram_we;
  logic [AW-1:0]  ram_addr;
  logic [31:0]    ram_rdata, resp_data;
  logic           read_resp;
  logic           unused_size;

  assign unused_size = ^lsu_size;

`ifdef MEM_RESPONDER_RANDOM_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign extra  = lfsr_q[1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign extra = 2'd0;
`endif

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cnt_d        = cnt_q;
    grant        = PORT_IFU;
    total        = CW'(LATENCY - 1) + CW'(extra);
    case (state_q)
      IDLE: begin
        if (ifu_reqValid || lsu_reqValid) begin
          if (ifu_reqValid && lsu_reqValid)
            grant = (last_grant_q == PORT_IFU) ? PORT_LSU : PORT_IFU;
          else if (lsu_reqValid)
            grant = PORT_LSU;
          port_d       = grant;
          last_grant_d = grant;
          if (grant == PORT_LSU) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
          if (total == '0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = total;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM access happens on the RESP entry edge; gating with reset drops stores during reset.
  assign ram_en   = reset && (state_d == RESP) && (state_q != RESP);
  assign ram_we   = wen_d && in_range(addr_d);
  assign ram_addr = AW'((addr_d - BASE) >> 2);

  mem_responder_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_d),
    .wmask (wmask_d),
    .rdata (ram_rdata)
  );

  assign ifu_respValid = (state_q == RESP) && (port_q == PORT_IFU);
  assign lsu_respValid = (state_q == RESP) && (port_q == PORT_LSU);
  assign read_resp     = (state_q == RESP) && !wen_q;
  assign resp_data     = in_range(addr_q) ? ram_rdata : OOR_DATA;

  // The registered RAM output is shown during RESP, then held by the per-port copy.
  assign ifu_rdata   = (ifu_respValid && read_resp) ? resp_data : ifu_rdata_q;
  assign lsu_rdata   = (lsu_respValid && read_resp) ? resp_data : lsu_rdata_q;
  assign ifu_rdata_d = ifu_rdata;
  assign lsu_rdata_d = lsu_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      port_q       <= PORT_IFU;
      last_grant_q <= PORT_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cnt_q        <= '0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expectations, a monitor checks responses.
module tb_mem_responder;

  localparam int          DEPTH = 16384;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          L     = 2;
  localparam logic [31:0] OOR   = 32'hDEAD_BEEF;
  localparam logic [31:0] SPAN  = DEPTH * 4;
`ifdef MEM_RESPONDER_RANDOM_DELAY_EN
  localparam int SLACK = 3;
  localparam int NRAND = 1000;
`else
  localparam int SLACK = 0;
  localparam int NRAND = 200;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [1:0]  lsu_size = 2'd2;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  typedef struct {
    bit          port;
    bit          wen;
    logic [31:0] data;
    int          exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[int];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(L), .OOR_DATA(OOR)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (ifu_respValid || lsu_respValid) begin
      total++;
      if (ifu_respValid && lsu_respValid) begin
        bad++;
        $display("FAIL dual_resp cycle=%0d both respValid high", cyc);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp cycle=%0d ifu=%0b lsu=%0b", cyc, ifu_respValid, lsu_respValid);
      end else begin
        exp_t e;
        bit          gp;
        logic [31:0] rd;
        e  = sb.pop_front();
        gp = lsu_respValid;
        rd = gp ? lsu_rdata : ifu_rdata;
        if (gp != e.port || cyc < e.exp || cyc > e.exp + SLACK || (!e.wen && rd !== e.data)) begin
          bad++;
          $display("FAIL resp port=%0d/%0d cycle=%0d exp_cycle=%0d..%0d rdata=%h exp=%h wen=%0b",
                   gp, e.port, cyc, e.exp, e.exp + SLACK, rd, e.data, e.wen);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic void mdl_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] off, w;
    int idx;
    off = a - BASE;
    if (off < SPAN) begin
      idx = int'(off >> 2);
      w = mdl.exists(idx) ? mdl[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (wm[i]) w[8*i +: 8] = wd[8*i +: 8];
      mdl[idx] = w;
    end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    logic [31:0] off;
    int idx;
    off = a - BASE;
    if (off >= SPAN) return OOR;
    idx = int'(off >> 2);
    return mdl.exists(idx) ? mdl[idx] : 32'h0;
  endfunction

  task automatic drive(input bit port, input logic [31:0] a, input bit wen,
                       input logic [31:0] wd, input logic [3:0] wm);
    if (port) begin
      lsu_reqValid = 1'b1; lsu_addr = a; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    end else begin
      ifu_reqValid = 1'b1; ifu_addr = a;
    end
  endtask

  task automatic drop(input bit port);
    if (port) begin
      lsu_reqValid = 1'b0; lsu_addr = 32'hFFFF_FFFF; lsu_wen = 1'b0; lsu_wdata = '1; lsu_wmask = '1;
    end else begin
      ifu_reqValid = 1'b0; ifu_addr = 32'hFFFF_FFFF;
    end
  endtask

  task automatic push(input bit port, input bit wen, input logic [31:0] d);
    exp_t e;
    e.port = port; e.wen = wen; e.data = d; e.exp = cyc - 1 + L;
    sb.push_back(e);
  endtask

  task automatic wait_resp(input bit port);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock);
      if (port ? lsu_respValid : ifu_respValid) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL resp_timeout port=%0d cycle=%0d", port, cyc);
    end
  endtask

  // Called in an IDLE cycle (#1 after a posedge); returns in the next IDLE cycle.
  task automatic xact(input bit port, input logic [31:0] a, input bit wen,
                      input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] exp_d);
    drive(port, a, wen, wd, wm);
    @(posedge clock); #1;
    drop(port);
    push(port, wen, exp_d);
    if (wen) mdl_store(a, wd, wm);
    wait_resp(port);
    @(posedge clock); #1;
  endtask

  task automatic tie(input bit first, input logic [31:0] ia, input logic [31:0] iexp,
                     input logic [31:0] la, input logic [31:0] lexp);
    bit other;
    other = ~first;
    drive(1'b0, ia, 1'b0, '0, '0);
    drive(1'b1, la, 1'b0, '0, '0);
    @(posedge clock); #1;
    drop(first);
    push(first, 1'b0, first ? lexp : iexp);
    wait_resp(first);
    @(posedge clock);
    @(posedge clock); #1;
    drop(other);
    push(other, 1'b0, other ? lexp : iexp);
    wait_resp(other);
    @(posedge clock); #1;
  endtask

  initial begin
    drop(1'b0);
    drop(1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ifu_rdata", ifu_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);
    chk("rst_respValid", {30'h0, ifu_respValid, lsu_respValid}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Basic store then fetch.
    xact(1'b1, 32'h8000_0000, 1'b1, 32'h0010_0073, 4'hF, 32'h0);
    xact(1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'h0010_0073);

    // Byte-lane store merge.
    xact(1'b1, 32'h8000_0010, 1'b1, 32'h1122_3344, 4'hF, 32'h0);
    xact(1'b1, 32'h8000_0011, 1'b1, 32'h0000_AB00, 4'b0010, 32'h0);
    xact(1'b1, 32'h8000_0010, 1'b0, '0, '0, 32'h1122_AB44);

    // Round-robin: after an IFU grant a tie goes to LSU; after an LSU grant it goes to IFU.
    xact(1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'h0010_0073);
    tie(1'b1, 32'h8000_0000, 32'h0010_0073, 32'h8000_0010, 32'h1122_AB44);
    xact(1'b1, 32'h8000_0000, 1'b0, '0, '0, 32'h0010_0073);
    tie(1'b0, 32'h8000_0010, 32'h1122_AB44, 32'h8000_0000, 32'h0010_0073);

    // Out-of-range accesses.
    xact(1'b0, 32'h7FFF_FFFC, 1'b0, '0, '0, OOR);
    xact(1'b1, BASE + SPAN, 1'b1, 32'h1234_5678, 4'hF, 32'h0);
    chk("lsu_rdata_hold_after_store", lsu_rdata, 32'h0010_0073);
    xact(1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'h0010_0073);
    xact(1'b1, BASE + SPAN + 32'd8, 1'b0, '0, '0, OOR);

    // Reset during WAIT aborts a store.
    drive(1'b1, 32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'hF);
    @(posedge clock); #1;
    drop(1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ifu_rdata", ifu_rdata, 32'h0);
    chk("midrst_lsu_rdata", lsu_rdata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("postrst_respValid", {30'h0, ifu_respValid, lsu_respValid}, 32'h0);
    chk("postrst_lsu_rdata", lsu_rdata, 32'h0);
    @(posedge clock); #1;
    xact(1'b1, 32'h8000_0010, 1'b0, '0, '0, 32'h1122_AB44);

    // Random traffic against the reference model in a small window.
    for (int w = 0; w < 16; w++)
      xact(1'b1, BASE + 32'(4 * w), 1'b1, $urandom, 4'hF, 32'h0);
    for (int n = 0; n < NRAND; n++) begin
      int          kind;
      logic [31:0] a, wd;
      logic [3:0]  wm;
      kind = $urandom_range(0, 2);
      a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 0) ? (BASE - 32'd4) : (BASE + SPAN);
      wd = $urandom;
      wm = 4'($urandom_range(0, 15));
      case (kind)
        0:       xact(1'b0, a, 1'b0, '0, '0, mdl_read(a));
        1:       xact(1'b1, a, 1'b0, '0, '0, mdl_read(a));
        default: xact(1'b1, a, 1'b1, wd, wm, 32'h0);
      endcase
    end

    repeat (4) @(posedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's two request/response ports: instruction fetch (ifu, read-only) and load/store (lsu, read/write).
- Owns one word-organised RAM and arbitrates both ports onto it, one transaction in flight.
- Each request is answered with a one-cycle respValid pulse after a configurable latency.
- Serves as the simulation memory in the SoC top and as the DUT partner in CPU benches.

Parameters:
- DEPTH, 16384: RAM size in 32-bit words; must be a power of two.
- BASE, 32'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from the acceptance edge to the cycle with respValid high; must be ≥1.
- OOR_DATA, 32'hDEAD_BEEF: rdata returned for an out-of-range read.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low.
- ifu_reqValid, input, 1: fetch request.
- ifu_addr, input, 32: fetch byte address.
- ifu_respValid, output, 1: fetch response pulse.
- ifu_rdata, output, 32: fetched word.
- lsu_reqValid, input, 1: load/store request.
- lsu_addr, input, 32: byte address.
- lsu_size, input, 2: 0 = byte, 1 = half, 2 = word; informational only.
- lsu_wen, input, 1: 1 = store.
- lsu_wdata, input, 32: store data, already lane-aligned.
- lsu_wmask, input, 4: byte-lane enables.
- lsu_respValid, output, 1: load/store response pulse.
- lsu_rdata, output, 32: aligned load word.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; both respValid 0; both rdata 0; latency counter 0; last_grant = IFU. RAM contents are not reset.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - Samples both reqValid.
  - With no request, stays in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not last_grant (round-robin).
  - On grant, latch port, addr, wen, wdata and wmask; update last_grant.
  - Go to RESP if LATENCY == 1; otherwise go to WAIT with counter = LATENCY-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - reqValid inputs are ignored in this state.
- Entry to RESP (same edge):
  - Word index = (addr - BASE) >> 2.
  - In range means (addr - BASE) < DEPTH*4.
  - Read: rdata register ← RAM[index], or OOR_DATA if out of range.
  - Store: for each lane i with wmask[i] = 1, RAM[index] byte i ← wdata byte i; out-of-range stores are dropped. rdata is unchanged on a store.
  - addr[1:0] is ignored; the lane position is carried by wmask and wdata.
- RESP:
  - The granted port's respValid = 1 for exactly one cycle; the other port's respValid = 0.
  - rdata holds its value until the next read response on that port.
  - The next state is always IDLE.
  - Requesters must drop reqValid by the cycle after respValid. A reqValid still high in the following IDLE cycle is a new request.
- Latency: accept at the edge ending IDLE cycle a; respValid is high in cycle a+LATENCY. Minimum back-to-back period is LATENCY+1 cycles.
- Request content on a port must stay stable from reqValid high until the acceptance edge. Changes after acceptance are ignored.
- Reset asserted mid-transaction aborts it: no respValid. A store is dropped if reset asserts before the RESP entry edge.
- Read-after-write to the same word in consecutive transactions returns the new data.

Optional Feature:
- Macro: MEM_RESPONDER_RANDOM_DELAY_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, reset value, advances every cycle) adds 0-3 extra WAIT cycles per transaction.
  - The extra count comes from LFSR[1:0] sampled at acceptance.
  - Used for CPU handshake robustness tests.
- Undefined: latency is exactly LATENCY; no LFSR logic is present.

Decomposition:
- Package mem_responder_pkg holds:
  - typedef enum of state_t {IDLE, WAIT, RESP};
  - typedef enum of port_t {PORT_IFU, PORT_LSU};
  - size encodings SIZE_B = 0, SIZE_H = 1, SIZE_W = 2;
  - default BASE and OOR_DATA.
- One sub-module, mem_responder_ram: DEPTH×32 single-port RAM with byte write enables and synchronous read.

Test Plan:
- LATENCY=2, RAM[0]=32'h0010_0073, ifu read at 32'h8000_0000 (accepted cycle 5) -> ifu_respValid high in cycle 7 only, ifu_rdata=32'h0010_0073, lsu_respValid stays 0.
- lsu store 32'h0000_AB00, wmask 4'b0010 at 32'h8000_0011, then lsu word load at 32'h8000_0010 (prior value 32'h1122_3344) -> load returns 32'h1122_AB44.
- Both ports request in the same IDLE cycle with last_grant=IFU -> LSU served first; IFU served LATENCY+1 cycles later; reversed on the next tie.
- ifu read at 32'h7FFF_FFFC -> rdata 32'hDEAD_BEEF; lsu store at BASE+DEPTH*4 -> no RAM change.
- Reset low during WAIT of a store -> no respValid, RAM word unchanged; after release, FSM in IDLE and outputs at reset values.
- With MEM_RESPONDER_RANDOM_DELAY_EN, 1000 random ifu/lsu transactions -> every response latency is in LATENCY..LATENCY+3 and read data matches a reference model.
